// File: rtl/key_tx_queue.sv
// Queues switch bytes (button) and PS/2 scancodes in a FIFO and paces them out to a UART transmitter.
// Optional build macro KEY_RELEASE_FILTER_EN drops the PS/2 break prefix 8'hF0 and the code after it.
module key_tx_queue #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      sw,
    input  logic                   btn_pulse,
    input  logic [7:0]             ps2_code,
    input  logic                   ps2_valid,
    output logic [DATA_W-1:0]      tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [7:0]             last_code,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // A zero gap skips the GAP state entirely rather than spending a cycle in it.
    localparam state_t AFTER_FRAME = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_t            state_q, state_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [GAP_W-1:0]  gcnt_q, gcnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [7:0]        last_code_q, last_code_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              ps2_accept_s;
    logic              wr_req_s, wr_do_s, rd_en_s, pend_drain_s;
    logic [DATA_W-1:0] wr_data_s;

`ifdef KEY_RELEASE_FILTER_EN
    logic skip_q, skip_d;

    // Break-code filter: F0 arms the skip flag, the following code is swallowed.
    always_comb begin
        skip_d       = skip_q;
        ps2_accept_s = 1'b0;
        if (ps2_valid) begin
            if (ps2_code == 8'hF0) begin
                skip_d = 1'b1;
            end else if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                ps2_accept_s = 1'b1;
            end
        end else begin
            skip_d = skip_q;
        end
    end
`else
    // Every PS/2 strobe is accepted when no filtering is built in.
    always_comb begin
        ps2_accept_s = ps2_valid;
    end
`endif

    // Source arbitration, pending register, FIFO pointers/level and storage.
    always_comb begin
        wr_req_s     = btn_pulse | pend_vld_q;
        wr_data_s    = btn_pulse ? sw : pend_data_q;
        rd_en_s      = (state_q == S_IDLE) && (level_q != LVL_ZERO);
        wr_do_s      = wr_req_s && ((level_q != LVL_FULL) || rd_en_s);
        pend_drain_s = pend_vld_q && !btn_pulse;

        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        if (ps2_accept_s) begin
            pend_vld_d  = 1'b1;
            pend_data_d = DATA_W'(ps2_code);
        end else if (pend_drain_s) begin
            pend_vld_d = 1'b0;
        end else begin
            pend_vld_d = pend_vld_q;
        end

        // Losses: a FIFO write refused while full, or a pending code overwritten before it drained.
        overflow_d  = overflow_q | (wr_req_s & ~wr_do_s) | (ps2_accept_s & pend_vld_q & btn_pulse);
        last_code_d = ps2_accept_s ? ps2_code : last_code_q;

        wr_ptr_d = wr_do_s ? wr_ptr_q + PTR_W'(1'b1) : wr_ptr_q;
        rd_ptr_d = rd_en_s ? rd_ptr_q + PTR_W'(1'b1) : rd_ptr_q;
        case ({wr_do_s, rd_en_s})
            2'b10:   level_d = level_q + LVL_W'(1'b1);
            2'b01:   level_d = level_q - LVL_W'(1'b1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == LVL_ZERO);

        mem_d           = mem_q;
        mem_d[wr_ptr_q] = wr_do_s ? wr_data_s : mem_q[wr_ptr_q];
    end

    // Transmit sequencer: pop, strobe, wait out the frame (with busy timeout), then pace.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        gcnt_d     = gcnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (rd_en_s) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                wcnt_d  = 2'd0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end else if (wcnt_q == 2'd3) begin
                    gcnt_d  = {GAP_W{1'b0}};
                    state_d = AFTER_FRAME;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    gcnt_d  = {GAP_W{1'b0}};
                    state_d = AFTER_FRAME;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1'b1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 2'd0;
            gcnt_q      <= {GAP_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= LVL_ZERO;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= {DATA_W{1'b0}};
            last_code_q <= 8'h00;
            tx_data_q   <= {DATA_W{1'b0}};
            tx_start_q  <= 1'b0;
`ifdef KEY_RELEASE_FILTER_EN
            skip_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            gcnt_q      <= gcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            last_code_q <= last_code_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
`ifdef KEY_RELEASE_FILTER_EN
            skip_q      <= skip_d;
`endif
        end
    end

    // FIFO storage needs no reset; stale entries are never read past the level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign last_code = last_code_q;
    assign level     = level_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;

endmodule
